// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose:
//   Holds the fetch FSM state encoding and the default constants used by
//   fetch_stage and if_id_reg.
//
// Contents:
//   fetch_state_t     - IDLE / REQ / WAIT / HOLD encoding of the fetch FSM
//   NOP_INSTR_DEFAULT - addi x0,x0,0, used for empty or flushed IF/ID slots
//   RESET_PC_DEFAULT  - PC loaded at reset
//   pc_align          - forces a byte address onto a 4-byte boundary

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold, flush and NOP insertion
//
// Purpose:
//   Pipeline register between fetch and decode. Priority per cycle:
//     flush  -> slot emptied (valid=0, instruction=NOP), pc fields held
//     load   -> slot takes {1, load_pc, load_instr, load_pc+4}
//     hold   -> every field keeps its value
//     else   -> bubble: valid=0, instruction=NOP, pc fields held
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   flush             - discard the slot contents
//   load              - capture a new instruction
//   hold              - freeze the slot
//   load_pc           - PC of the instruction being loaded
//   load_instr        - instruction word being loaded
//   id_valid          - slot holds a real instruction
//   id_pc             - PC of the slot instruction
//   id_instruction    - slot instruction word
//   id_pc_plus4       - id_pc + 4 (link value)

module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic        hold,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_plus4
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid       <= 1'b0;
            id_pc          <= 32'd0;
            id_instruction <= NOP_INSTR;
            id_pc_plus4    <= 32'd0;
        end else if (flush) begin
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
        end else if (load) begin
            id_valid       <= 1'b1;
            id_pc          <= load_pc;
            id_instruction <= load_instr;
            // Modulo 2^32: a fetch at 32'hFFFF_FFFC links to 0.
            id_pc_plus4    <= load_pc + 32'd4;
        end else if (!hold) begin
            // Nothing arrived this cycle: present a bubble to decode but keep
            // the pc fields so debug views still show the last real PC.
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with one outstanding imem request
//
// Purpose:
//   Owns the PC, issues requests to a variable-latency instruction memory
//   (one outstanding at a time) and feeds decode through the IF/ID register.
//   Honours stall from the hazard unit and redirect from EX; a redirect
//   outranks stall and every FSM transition.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   imem_req          - fetch request valid (state == REQ)
//   imem_addr         - fetch address, always the PC register
//   imem_ready        - memory accepts the request this cycle
//   imem_rvalid       - response valid (never in the acceptance cycle)
//   imem_rdata        - fetched instruction word
//   stall             - hold the IF/ID register
//   redirect          - flush and change the PC
//   redirect_target   - new PC when redirect=1 (low two bits ignored)
//   id_valid          - IF/ID holds a real instruction
//   id_pc             - PC of the IF/ID instruction
//   id_instruction    - instruction word to decode
//   id_pc_plus4       - id_pc + 4

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_plus4
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetch_pc;
    logic         kill;
    logic [31:0]  buf_instr;

    logic         deliver_resp;
    logic         deliver_buf;
    logic         ifid_load;
    logic [31:0]  ifid_instr;

    // Target bits [1:0] are dropped by alignment.
    logic         unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];

    // Request interface depends only on state and pc, so stall/redirect
    // never create a combinational path to the memory.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // A response goes straight to IF/ID only when it is wanted and decode
    // can take it; a stalled response waits in the one-entry buffer.
    assign deliver_resp = (state == WAIT) && imem_rvalid && !kill
                          && !stall && !redirect;
    assign deliver_buf  = (state == HOLD) && !stall && !redirect;
    assign ifid_load    = deliver_resp || deliver_buf;
    assign ifid_instr   = deliver_buf ? buf_instr : imem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            fetch_pc  <= RESET_PC;
            kill      <= 1'b0;
            buf_instr <= NOP_INSTR;
        end else if (redirect) begin
            pc        <= pc_align(redirect_target);
            buf_instr <= NOP_INSTR;
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ready) begin
                        // The memory already took the old pc; its response
                        // must be swallowed when it comes back.
                        fetch_pc <= pc;
                        kill     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= REQ;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                HOLD: state <= REQ;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ready) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else if (!stall) begin
                            state <= REQ;
                        end else begin
                            buf_instr <= imem_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        buf_instr <= NOP_INSTR;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // While in HOLD no new request has been accepted, so fetch_pc is still
    // the PC of the buffered instruction.
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .flush          (redirect),
        .load           (ifid_load),
        .hold           (stall),
        .load_pc        (fetch_pc),
        .load_instr     (ifid_instr),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_pc_plus4    (id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] I0    = 32'h0050_0093;
    localparam logic [31:0] I4    = 32'h00a0_0113;
    localparam logic [31:0] I8    = 32'h0030_0193;
    localparam logic [31:0] I12   = 32'h0040_0213;
    localparam logic [31:0] I16   = 32'h0060_0293;
    localparam logic [31:0] I100  = 32'h0070_0313;
    localparam logic [31:0] I200  = 32'h0080_0393;
    localparam logic [31:0] IFFC  = 32'h0090_0413;
    localparam logic [31:0] IJUNK = 32'hdead_beef;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic [31:0] id_pc_plus4;

    int checks;
    int errors;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction),
        .id_pc_plus4     (id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs for one rising edge, then return at the following
    // falling edge where outputs are sampled.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic stl, input logic redir, input logic [31:0] tgt);
        imem_ready      = rdy;
        imem_rvalid     = rv;
        imem_rdata      = rd;
        stall           = stl;
        redirect        = redir;
        redirect_target = tgt;
        @(posedge clk);
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] p,
                            input logic [31:0] ins, input logic [31:0] p4);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, ".pc"},    id_pc,          p);
        check({tag, ".instr"}, id_instruction, ins);
        check({tag, ".pc4"},   id_pc_plus4,    p4);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"},  {31'd0, imem_req}, {31'd0, r});
        check({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        imem_ready      = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'd0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_id("reset", 1'b0, 32'd0, NOP, 32'd0);
        check_req("reset", 1'b0, 32'd0);

        // Reset release, 1-cycle memory
        reset = 1'b0;
        check_req("idle", 1'b0, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check_req("first_req", 1'b1, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check_req("wait0", 1'b0, 32'd4);
        cyc(0, 1, I0, 0, 0, 0);
        check_id("fetch0", 1'b1, 32'd0, I0, 32'd4);
        check_req("req4", 1'b1, 32'd4);
        cyc(1, 0, 0, 0, 0, 0);
        check_id("bubble", 1'b0, 32'd0, NOP, 32'd4);
        cyc(0, 1, I4, 0, 0, 0);
        check_id("fetch4", 1'b1, 32'd4, I4, 32'd8);
        check_req("req8", 1'b1, 32'd8);
        cyc(1, 0, 0, 0, 0, 0);

        // Stall for 3 cycles rising with the response for 8
        cyc(0, 1, I8, 1, 0, 0);
        check_id("hold1", 1'b0, 32'd4, NOP, 32'd8);
        check_req("hold1", 1'b0, 32'd12);
        cyc(0, 0, 0, 1, 0, 0);
        check_req("hold2", 1'b0, 32'd12);
        cyc(0, 0, 0, 1, 0, 0);
        check_id("hold3", 1'b0, 32'd4, NOP, 32'd8);
        cyc(0, 0, 0, 0, 0, 0);
        check_id("unstall", 1'b1, 32'd8, I8, 32'd12);
        check_req("req12", 1'b1, 32'd12);
        // Stall with a valid slot keeps it intact
        cyc(1, 0, 0, 1, 0, 0);
        check_id("stall_valid", 1'b1, 32'd8, I8, 32'd12);

        // Redirect in WAIT with the response still pending
        cyc(0, 0, 0, 0, 1, 32'h0000_0100);
        check_id("redir_wait", 1'b0, 32'd8, NOP, 32'd12);
        check_req("redir_wait", 1'b0, 32'h100);
        cyc(0, 1, I12, 0, 0, 0);
        check_id("late_drop", 1'b0, 32'd8, NOP, 32'd12);
        check_req("req100", 1'b1, 32'h100);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, I100, 0, 0, 0);
        check_id("fetch100", 1'b1, 32'h100, I100, 32'h104);

        // Redirect in REQ without accept, then redirect with accept at pc=16
        cyc(0, 0, 0, 0, 1, 32'h0000_0010);
        check_req("req16", 1'b1, 32'h10);
        check_id("flush16", 1'b0, 32'h100, NOP, 32'h104);
        cyc(1, 0, 0, 0, 1, 32'h0000_0203);
        check_req("redir_acc", 1'b0, 32'h200);
        cyc(0, 1, I16, 0, 0, 0);
        check_id("drop16", 1'b0, 32'h100, NOP, 32'h104);
        check_req("req200", 1'b1, 32'h200);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, I200, 0, 0, 0);
        check_id("fetch200", 1'b1, 32'h200, I200, 32'h204);

        // PC wrap at the top of the address space
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        check_req("reqFFC", 1'b1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0);
        check_req("wrap_pc", 1'b0, 32'd0);
        cyc(0, 1, IFFC, 0, 0, 0);
        check_id("fetchFFC", 1'b1, 32'hFFFF_FFFC, IFFC, 32'd0);
        check_req("req_wrap", 1'b1, 32'd0);

        // Reset pulsed during WAIT, response arrives after release
        cyc(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_id("async_rst", 1'b0, 32'd0, NOP, 32'd0);
        check_req("async_rst", 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, IJUNK, 0, 0, 0);
        check_id("rst_ignore", 1'b0, 32'd0, NOP, 32'd0);
        check_req("rst_req", 1'b1, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, I0, 0, 0, 0);
        check_id("restart", 1'b1, 32'd0, I0, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
